// File: rtl/lsu_dcache_master.sv
// ---------------------------------------------------------------------------
// lsu_dcache_master
//
// Bridges a single outstanding pipeline load/store request onto a data-cache
// command/response channel. One request is accepted in IDLE, issued as an
// aligned doubleword command with byte strobes, and completed with a
// single-cycle done pulse. Load results are shifted down from the returned
// doubleword and sign/zero extended.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   defined   - accesses whose address is not size-aligned never reach the
//               cache; they complete one cycle after acceptance with
//               done_misalign=1 and done_data=0.
//   undefined - done_misalign is tied 0 and misaligned accesses are issued
//               as-is; bytes past the end of the doubleword are dropped.
//
// Ports
//   clk, reset                   clock, synchronous active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_addr/wen/wdata/size/unsigned   request fields (size 0=B,1=H,2=W,3=D)
//   dcache_cmd_valid/ready       command handshake
//   dcache_cmd_payload_*         aligned addr, wen, shifted wdata, wstrb, size
//   dcache_rsp_valid/payload_data   full aligned doubleword for loads
//   done_valid/data/misalign     one-cycle completion pulse and result
// ---------------------------------------------------------------------------
module lsu_dcache_master #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64  // only 64 is supported
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,

  output logic              dcache_cmd_valid,
  input  logic              dcache_cmd_ready,
  output logic [ADDR_W-1:0] dcache_cmd_payload_addr,
  output logic              dcache_cmd_payload_wen,
  output logic [DATA_W-1:0] dcache_cmd_payload_wdata,
  output logic [7:0]        dcache_cmd_payload_wstrb,
  output logic [2:0]        dcache_cmd_payload_size,

  input  logic              dcache_rsp_valid,
  input  logic [DATA_W-1:0] dcache_rsp_payload_data,

  output logic              done_valid,
  output logic [DATA_W-1:0] done_data,
  output logic              done_misalign
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e              state_q;

  // latched request attributes needed after acceptance
  logic                wen_q;
  logic                uns_q;
  logic [1:0]          size_q;
  logic [2:0]          off_q;

  // registered command payload
  logic                cmd_valid_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q;
  logic [7:0]          cmd_wstrb_q;

  // registered completion
  logic                done_valid_q;
  logic [DATA_W-1:0]   done_data_q;

  // -------------------------------------------------------------------------
  // Request-side formatting, evaluated on the live request fields so the
  // payload registers load already-formatted values on acceptance.
  // -------------------------------------------------------------------------
  logic [7:0]          mask_d;
  logic [7:0]          strb_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [ADDR_W-1:0]   addr_d;

  // Byte mask of the access width. 1<<8 wraps to 0 in 8 bits, so the
  // doubleword case yields 8'hFF after the subtraction.
  assign mask_d  = (8'd1 << (4'd1 << req_size)) - 8'd1;
  assign strb_d  = req_wen ? (mask_d << req_addr[2:0]) : 8'd0;
  assign wdata_d = req_wdata << {req_addr[2:0], 3'b000};
  assign addr_d  = {req_addr[ADDR_W-1:3], 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
  logic [2:0]          amask_d;
  logic                mis_d;
  logic                done_mis_q;

  // low-address bits that must be zero for the given size: 0,1,3,7
  assign amask_d = 3'((4'd1 << req_size) - 4'd1);
  assign mis_d   = |(req_addr[2:0] & amask_d);
`endif

  // -------------------------------------------------------------------------
  // Load result: bring the addressed bytes down to bit 0, then extend from
  // the access width. Bytes past the doubleword shift in as zero.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]   rsp_sh;
  logic [DATA_W-1:0]   load_d;

  assign rsp_sh = dcache_rsp_payload_data >> {off_q, 3'b000};

  always_comb begin
    load_d = rsp_sh;
    unique case (size_q)
      2'd0:    load_d = {{(DATA_W-8){~uns_q & rsp_sh[7]}},   rsp_sh[7:0]};
      2'd1:    load_d = {{(DATA_W-16){~uns_q & rsp_sh[15]}}, rsp_sh[15:0]};
      2'd2:    load_d = {{(DATA_W-32){~uns_q & rsp_sh[31]}}, rsp_sh[31:0]};
      default: load_d = rsp_sh;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'd0;
      off_q        <= 3'd0;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_wstrb_q  <= 8'd0;
      done_valid_q <= 1'b0;
      done_data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      done_mis_q   <= 1'b0;
`endif
    end else begin
      // done is a pulse: only set on the transition into DONE
      done_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wen_q       <= req_wen;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            off_q       <= req_addr[2:0];
            cmd_addr_q  <= addr_d;
            cmd_wdata_q <= wdata_d;
            cmd_wstrb_q <= strb_d;
`ifdef LSU_MISALIGN_TRAP_EN
            if (mis_d) begin
              // trapped access never touches the cache
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_data_q  <= '0;
              done_mis_q   <= 1'b1;
            end else begin
              done_mis_q   <= 1'b0;
`else
            begin
`endif
              state_q     <= CMD;
              cmd_valid_q <= 1'b1;
            end
          end
        end

        CMD: begin
          if (dcache_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            if (wen_q) begin
              // stores are posted: no response is expected
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_data_q  <= '0;
            end else begin
              state_q      <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          if (dcache_rsp_valid) begin
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_data_q  <= load_d;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Ready is qualified by reset so it reads 0 throughout reset and
  // 1 in the very first cycle reset is released.
  // -------------------------------------------------------------------------
  assign req_ready                = (state_q == IDLE) & reset;
  assign dcache_cmd_valid         = cmd_valid_q;
  assign dcache_cmd_payload_addr  = cmd_addr_q;
  assign dcache_cmd_payload_wen   = wen_q;
  assign dcache_cmd_payload_wdata = cmd_wdata_q;
  assign dcache_cmd_payload_wstrb = cmd_wstrb_q;
  assign dcache_cmd_payload_size  = {1'b0, size_q};
  assign done_valid               = done_valid_q;
  assign done_data                = done_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign done_misalign            = done_mis_q;
`else
  assign done_misalign            = 1'b0;
`endif

endmodule
